// File: rtl/fetch_stim_sequencer.sv
// Fetch-unit stimulus sequencer: replays a RAM script of control vectors,
// each held hold+1 cycles, optionally checking the returned PC per entry.
module fetch_stim_sequencer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int HOLDW = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ld_we_i,
    input  logic [AW-1:0]    ld_addr_i,
    input  logic [3:0]       ld_ctrl_i,
    input  logic [XLEN-1:0]  ld_r1_i,
    input  logic [XLEN-1:0]  ld_imm_i,
    input  logic [HOLDW-1:0] ld_hold_i,
    input  logic             ld_chk_i,
    input  logic [XLEN-1:0]  ld_exp_pc_i,
    input  logic [AW:0]      len_i,
    input  logic             loop_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [XLEN-1:0]  pc_instr_i,
    output logic             pc_rst_o,
    output logic             be_o,
    output logic             jalre_o,
    output logic             uje_o,
    output logic [XLEN-1:0]  r1_o,
    output logic [XLEN-1:0]  immed_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             mismatch_o,
    output logic [15:0]      err_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [3:0]       ctrl_mem [DEPTH];
    logic [XLEN-1:0]  r1_mem   [DEPTH];
    logic [XLEN-1:0]  imm_mem  [DEPTH];
    logic [HOLDW-1:0] hold_mem [DEPTH];
    logic             chk_mem  [DEPTH];
    logic [XLEN-1:0]  exp_mem  [DEPTH];

    state_t           state;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    len_last;
    logic [HOLDW-1:0] hold_cnt;

    logic [AW:0]      len_eff;
    logic [AW-1:0]    len_last_n;
    logic [AW-1:0]    nxt_idx;
    logic [AW-1:0]    load_idx;
    logic             start_ok;
    logic             wrap;
    logic             last_cycle;
    logic             chk_fail;

    // Script RAM has no reset so a loaded script survives rst_ni.
    always_ff @(posedge clk_i) begin
        if (ld_we_i && (state != S_RUN) && ({1'b0, ld_addr_i} < DEPTH_W)) begin
            ctrl_mem[ld_addr_i] <= ld_ctrl_i;
            r1_mem[ld_addr_i]   <= ld_r1_i;
            imm_mem[ld_addr_i]  <= ld_imm_i;
            hold_mem[ld_addr_i] <= ld_hold_i;
            chk_mem[ld_addr_i]  <= ld_chk_i;
            exp_mem[ld_addr_i]  <= ld_exp_pc_i;
        end
    end

    always_comb begin
        len_eff    = (len_i > DEPTH_W) ? DEPTH_W : len_i;
        len_last_n = AW'(len_eff - (AW+1)'(1));
        start_ok   = start_i && (len_i != '0);
        wrap       = (idx == len_last);
        nxt_idx    = wrap ? '0 : idx + AW'(1);
        last_cycle = (hold_cnt == '0);
        chk_fail   = chk_mem[idx] && (pc_instr_i != exp_mem[idx]);
        // Entry to present next: entry 0 on start, successor while running.
        load_idx   = (state == S_RUN) ? nxt_idx : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            idx        <= '0;
            len_last   <= '0;
            hold_cnt   <= '0;
            pc_rst_o   <= 1'b0;
            jalre_o    <= 1'b0;
            uje_o      <= 1'b0;
            be_o       <= 1'b0;
            r1_o       <= '0;
            immed_o    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            mismatch_o <= 1'b0;
            err_cnt_o  <= '0;
        end else begin
            done_o     <= 1'b0;
            mismatch_o <= 1'b0;
            if (stop_i) begin
                state    <= S_IDLE;
                busy_o   <= 1'b0;
                {pc_rst_o, jalre_o, uje_o, be_o} <= '0;
                r1_o     <= '0;
                immed_o  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            state     <= S_RUN;
                            busy_o    <= 1'b1;
                            idx       <= '0;
                            len_last  <= len_last_n;
                            hold_cnt  <= hold_mem[load_idx];
                            err_cnt_o <= '0;
                            {pc_rst_o, jalre_o, uje_o, be_o} <= ctrl_mem[load_idx];
                            r1_o      <= r1_mem[load_idx];
                            immed_o   <= imm_mem[load_idx];
                        end
                    end
                    S_RUN: begin
                        if (last_cycle) begin
                            if (chk_fail) begin
                                mismatch_o <= 1'b1;
                                if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
                            end
                            if (!wrap || loop_i) begin
                                idx      <= nxt_idx;
                                hold_cnt <= hold_mem[load_idx];
                                {pc_rst_o, jalre_o, uje_o, be_o} <= ctrl_mem[load_idx];
                                r1_o     <= r1_mem[load_idx];
                                immed_o  <= imm_mem[load_idx];
                            end else begin
                                state    <= S_DONE;
                                busy_o   <= 1'b0;
                                done_o   <= 1'b1;
                                {pc_rst_o, jalre_o, uje_o, be_o} <= '0;
                                r1_o     <= '0;
                                immed_o  <= '0;
                            end
                        end else begin
                            hold_cnt <= hold_cnt - HOLDW'(1);
                        end
                    end
                    S_DONE: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
